// File: rtl/sram_8x8_sync.sv
// sram_8x8_sync: 8x8 single-port synchronous RAM.
// Registered read port with a read-valid strobe and write-first collisions.
module sram_8x8_sync #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;
  logic              r_vld;
  logic [DATA_W-1:0] w_rdata;

  // Write-first: a colliding write forwards its data to the read port.
  assign w_rdata = wr ? data_in : r_mem[addr];

  // Storage array: cleared on reset, otherwise written on wr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= RESET_VAL;
    end else if (wr) begin
      r_mem[addr] <= data_in;
    end
  end

  // Read port: data register holds between reads, valid pulses per read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout <= RESET_VAL;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= rd;
      if (rd)
        r_dout <= w_rdata;
    end
  end

  assign data_out = r_dout;
  assign rd_valid = r_vld;

endmodule

// File: tb/tb_sram_8x8_sync.sv
// tb_sram_8x8_sync: directed and random checks of sram_8x8_sync
// against an array-based reference model.
module tb_sram_8x8_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       wr;
  logic       rd;
  logic [2:0] addr;
  logic [7:0] data_out;
  logic       rd_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_mem [8];
  logic [7:0] m_dout;
  logic       m_vld;

  sram_8x8_sync #(
    .DATA_W(8),
    .ADDR_W(3),
    .RESET_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .wr(wr),
    .rd(rd),
    .addr(addr),
    .data_out(data_out),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance model at posedge, compare after.
  task automatic step(input logic r, input logic w, input logic d,
                      input logic [2:0] a, input logic [7:0] din);
    @(negedge clk);
    rst_n = r; wr = w; rd = d; addr = a; data_in = din;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_dout = 8'h00;
      m_vld = 1'b0;
    end else begin
      m_vld = d;
      if (d) m_dout = w ? din : m_mem[a];
      if (w) m_mem[a] = din;
    end
    #1;
    cmp("model_dout", data_out, m_dout);
    cmp("model_vld", {7'b0, rd_valid}, {7'b0, m_vld});
  endtask

  initial begin
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_dout = 8'h00;
    m_vld = 1'b0;

    // reset with a write pending
    step(1'b0, 1'b1, 1'b0, 3'd1, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 3'd1, 8'hFF);
    cmp("rst_dout", data_out, 8'h00);
    cmp("rst_vld", {7'b0, rd_valid}, 8'h00);
    step(1'b1, 1'b0, 1'b1, 3'd1, 8'h00);
    cmp("rst_read1", data_out, 8'h00);
    cmp("rst_read1_vld", {7'b0, rd_valid}, 8'h01);

    // basic write then read, then hold
    step(1'b1, 1'b1, 1'b0, 3'd1, 8'b00111110);
    step(1'b1, 1'b0, 1'b1, 3'd1, 8'h00);
    cmp("basic_rd", data_out, 8'h3E);
    step(1'b1, 1'b0, 1'b0, 3'd1, 8'h00);
    cmp("basic_hold", data_out, 8'h3E);
    cmp("basic_hold_vld", {7'b0, rd_valid}, 8'h00);

    // full sweep
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 3'(i), 8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 3'(i), 8'h00);
      cmp($sformatf("sweep_%0d", i), data_out, 8'h10 + 8'(i));
    end

    // simultaneous write and read
    step(1'b1, 1'b1, 1'b0, 3'd3, 8'hAA);
    step(1'b1, 1'b1, 1'b1, 3'd3, 8'h55);
    cmp("wr_rd_fwd", data_out, 8'h55);
    step(1'b1, 1'b0, 1'b1, 3'd3, 8'h00);
    cmp("wr_rd_mem", data_out, 8'h55);

    // write alone leaves output untouched
    step(1'b1, 1'b0, 1'b1, 3'd2, 8'h00);
    cmp("nodist_rd", data_out, 8'h12);
    step(1'b1, 1'b1, 1'b0, 3'd2, 8'h99);
    cmp("nodist_wr", data_out, 8'h12);
    step(1'b1, 1'b0, 1'b0, 3'd2, 8'h00);
    cmp("nodist_idle", data_out, 8'h12);
    step(1'b1, 1'b0, 1'b1, 3'd2, 8'h00);
    cmp("nodist_new", data_out, 8'h99);

    // reset mid-sequence with rd high
    step(1'b0, 1'b0, 1'b1, 3'd5, 8'h00);
    cmp("midrst_dout", data_out, 8'h00);
    cmp("midrst_vld", {7'b0, rd_valid}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 3'(i), 8'h00);
      cmp($sformatf("midrst_rd_%0d", i), data_out, 8'h00);
    end

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 59) != 0),
           1'($urandom), 1'($urandom),
           3'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_8x8_sync.md
Name: sram_8x8_sync

Overview:
- Small single-port synchronous static RAM: 8 words x 8 bits, one address bus, separate write-data and read-data buses.
- Write and read strobes are sampled on the rising clock edge.
- Used as a local scratch/register store inside a larger datapath.
- Read data is registered and holds between reads.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W (8 words).
- RESET_VAL, 0, value loaded into every memory word and into data_out on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- data_in  in  DATA_W  write data.
- wr  in  1  write enable, active high.
- rd  in  1  read enable, active high.
- addr  in  ADDR_W  word address for both read and write.
- data_out  out  DATA_W  registered read data.
- rd_valid  out  1  high for one cycle after a clock edge that performed a read.

Behaviour:
- All state changes happen only on the rising edge of clk; there are no asynchronous paths.
- Reset: rst_n sampled low at a rising edge, synchronous active-low; the polarity and synchronicity are fixed.
  - All 8 memory words load RESET_VAL.
  - data_out loads RESET_VAL.
  - rd_valid loads 0.
  - Reset overrides wr and rd in the same cycle.
  - A reset asserted mid-sequence discards all stored data.
- Write: wr=1 at a rising edge stores data_in into mem[addr] at that edge.
- Read:
  - rd=1 at a rising edge loads data_out with the word at addr; the value is valid after that edge (1-cycle latency from the sampling edge).
  - rd_valid goes 1 for that cycle.
- Idle: rd=0 means data_out holds its previous value and rd_valid=0.
- Simultaneous wr=1 and rd=1:
  - The write is performed.
  - data_out receives data_in (write-first / write-through); the old contents are never returned.
  - rd_valid=1.
- A write alone (rd=0) never changes data_out.
- Address range: all 2**ADDR_W addresses are valid. No out-of-range case exists and there is no wrap logic.
- addr, data_in, wr and rd are ordinary synchronous inputs sampled only at the edge.
- Memory contents persist indefinitely between reset events.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with wr=1, addr=3'd1, data_in=8'hFF.
  - data_out=8'h00 and rd_valid=0.
  - After release, read addr 1 -> 8'h00.
- Basic write/read: write 8'b00111110 to addr 1, then next cycle wr=0, rd=1, addr=1.
  - After that edge data_out=8'b00111110 and rd_valid=1.
  - data_out holds that value while rd=0.
- Full sweep: write addr i with data 8'h10+i for i=0..7, then read 0..7.
  - Each read returns 8'h10+i one edge after sampling.
  - Verifies no aliasing, including addr 7 and addr 0.
- Simultaneous wr=1, rd=1: addr 3 holds 8'hAA; apply data_in=8'h55.
  - data_out=8'h55 and mem[3]=8'h55 (a later read returns 8'h55).
- Write does not disturb output: read addr 2 (8'h12), then write 8'h99 to addr 2 with rd=0.
  - data_out stays 8'h12 until the next read, which returns 8'h99.
- Reset mid-operation: after the sweep, assert rst_n=0 for one edge while rd=1.
  - data_out=8'h00 and rd_valid=0.
  - Subsequent reads of all addresses return 8'h00.
